// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: PC/fetch front end with credit-limited in-order queue, redirect drop and HLT stop; FETCH_PERF_CNT_EN adds fetch/drop counters
module fetch_issue_unit #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   output logic [DATA_W-1:0] dec_instr,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [ADDR_W-1:0] dec_pc_plus2,
   input  logic              dec_ready,
   output logic              halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_count,
   output logic [15:0]       drop_count
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   typedef enum logic {RUN, HALT} state_t;
   state_t state;
   logic [ADDR_W-1:0] pc, rsp_pc, redir_pc;
   logic [CW-1:0] inflight, inflight_n, drop, cnt;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic hlt_seen, redir, req_fire, rsp_ok, dropping, enq, discard, pop, pop_hlt;
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [ADDR_W-1:0] q_pc [DEPTH];
   // rsp_pc tracks the PC of the next non-dropped response, since responses return in order
   always_comb begin
      redir = redirect_valid && state == RUN;
      redir_pc = redirect_pc & ~ADDR_W'(1);
      imem_req_valid = !rst && state == RUN && !hlt_seen && ((CW+1)'(inflight) + (CW+1)'(cnt) < (CW+1)'(DEPTH));
      imem_req_addr = pc;
      req_fire = imem_req_valid && imem_req_ready;
      rsp_ok = imem_rsp_valid && inflight != '0;
      dropping = rsp_ok && drop != '0;
      enq = rsp_ok && drop == '0 && !hlt_seen && state == RUN && !redir;
      discard = rsp_ok && drop == '0 && !enq;
      inflight_n = inflight + CW'(req_fire) - CW'(rsp_ok);
      dec_valid = cnt != '0;
      dec_instr = dec_valid ? q_data[rd_ptr] : '0;
      dec_pc = dec_valid ? q_pc[rd_ptr] : '0;
      dec_pc_plus2 = dec_valid ? dec_pc + ADDR_W'(2) : '0;
      pop = dec_valid && dec_ready && !redir;
      pop_hlt = pop && dec_instr[DATA_W-1 -: 4] == 4'hF;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         pc <= RESET_PC;
         rsp_pc <= RESET_PC;
         inflight <= '0;
         drop <= '0;
         cnt <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         hlt_seen <= 1'b0;
         halted <= 1'b0;
      end else begin
         inflight <= inflight_n;
         if (redir) begin
            pc <= redir_pc;
            rsp_pc <= redir_pc;
            drop <= inflight_n;
            cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            hlt_seen <= 1'b0;
         end else begin
            if (req_fire) pc <= pc + ADDR_W'(2);
            if (dropping) drop <= drop - 1'b1;
            if (rsp_ok && drop == '0) rsp_pc <= rsp_pc + ADDR_W'(2);
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (enq && imem_rsp_data[DATA_W-1 -: 4] == 4'hF) hlt_seen <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(enq) - CW'(pop);
            if (pop_hlt) begin
               state <= HALT;
               halted <= 1'b1;
               cnt <= '0;
               wr_ptr <= '0;
               rd_ptr <= '0;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (enq) begin
         q_data[wr_ptr] <= imem_rsp_data;
         q_pc[wr_ptr] <= rsp_pc;
      end
   end
`ifdef FETCH_PERF_CNT_EN
   logic [CW-1:0] flushed;
   logic [CW+1:0] ndrop;
   logic [16:0] drop_sum;
   always_comb begin
      flushed = redir ? cnt : pop_hlt ? cnt - 1'b1 : '0;
      ndrop = (CW+2)'(flushed) + (CW+2)'(dropping) + (CW+2)'(discard);
      drop_sum = {1'b0, drop_count} + 17'(ndrop);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= '0;
         drop_count <= '0;
      end else begin
         if (pop && fetch_count != '1) fetch_count <= fetch_count + 1'b1;
         drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
      end
   end
`endif
endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit: directed checks of fetch order, backpressure, redirect, HLT stop and PC wrap
`timescale 1ns/1ps
module tb_fetch_issue_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic imem_req_valid, dec_valid, halted;
   logic imem_req_ready = 1'b1;
   logic imem_rsp_valid = 1'b0;
   logic redirect_valid = 1'b0;
   logic dec_ready = 1'b0;
   logic [15:0] imem_req_addr, dec_instr, dec_pc, dec_pc_plus2;
   logic [15:0] imem_rsp_data = '0;
   logic [15:0] redirect_pc = '0;
   logic w_req_valid, w_dec_valid, w_halted;
   logic [15:0] w_req_addr, w_dec_instr, w_dec_pc, w_dec_pc_plus2;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, w_fetch_count;
   logic [15:0] drop_count, w_drop_count;
`endif
   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int lat = 1;
   int req_n = 0;
   int pop_cnt = 0;
   int pop_done = 0;
   int max_out = 0;
   int late_req = 0;
   bit hlt_on = 1'b0;
   bit hlt_vis = 1'b0;
   int due_q[$];
   logic [15:0] addr_q[$];
   always #5 clk = ~clk;
   fetch_issue_unit u_dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus2(dec_pc_plus2),
      .dec_ready(dec_ready), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fetch_count), .drop_count(drop_count)
`endif
   );
   // Shadow instance starting at the top of memory; it sees the same response timing as u_dut
   fetch_issue_unit #(.RESET_PC(16'hFFFE)) u_wrap (
      .clk(clk), .rst(rst),
      .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(w_dec_valid), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .dec_pc_plus2(w_dec_pc_plus2),
      .dec_ready(dec_ready), .halted(w_halted)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(w_fetch_count), .drop_count(w_drop_count)
`endif
   );
   function automatic logic [15:0] instr(input logic [15:0] a);
      if (hlt_on && a == 16'h0006) return 16'hF000;
      case (a)
         16'h0000: return 16'h1123;
         16'h0002: return 16'h2456;
         16'h0004: return 16'h8789;
         default:  return {4'h3, a[11:0]};
      endcase
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      cyc++;
      pop_done = pop_cnt;
      if (rst) begin
         due_q.delete();
         addr_q.delete();
         imem_rsp_valid = 1'b0;
         return;
      end
      if (due_q.size() != 0 && due_q[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = instr(addr_q[0]);
         void'(due_q.pop_front());
         void'(addr_q.pop_front());
      end else imem_rsp_valid = 1'b0;
      if (dec_valid && dec_instr == 16'hF000) hlt_vis = 1'b1;
      if (imem_req_valid) begin
         due_q.push_back(cyc + lat);
         addr_q.push_back(imem_req_addr);
         req_n++;
         if (hlt_vis) late_req++;
      end
      if (dec_valid && dec_ready) pop_cnt++;
      if (req_n - pop_cnt > max_out) max_out = req_n - pop_cnt;
   endtask
   task automatic do_reset(input bit rdy, input int l);
      rst = 1'b1;
      redirect_valid = 1'b0;
      dec_ready = rdy;
      lat = l;
      hlt_vis = 1'b0;
      late_req = 0;
      req_n = 0;
      pop_cnt = 0;
      max_out = 0;
      tick();
      tick();
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr", imem_req_addr, 16'h0000);
      check("rst_dec_valid", dec_valid, 0);
      check("rst_dec_pc2", dec_pc_plus2, 0);
      check("rst_halted", halted, 0);
      check("rst_wrap_addr", w_req_addr, 16'hFFFE);
      @(posedge clk);
      #2 rst = 1'b0;
   endtask
   task automatic next_pop(input string tag, input logic [15:0] exp_pc, input logic [15:0] exp_instr);
      logic [15:0] pc, ins, p2;
      pc = 'x;
      ins = 'x;
      p2 = 'x;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (dec_valid && dec_ready) begin
            pc = dec_pc;
            ins = dec_instr;
            p2 = dec_pc_plus2;
            break;
         end
      end
      check({tag, "_pc"}, pc, exp_pc);
      check({tag, "_instr"}, ins, exp_instr);
      check({tag, "_pc2"}, p2, 16'(exp_pc + 16'd2));
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      // basic fetch at latency 1, plus wrap from 16'hFFFE on the shadow instance
      do_reset(1'b1, 1);
      tick();
      check("t1_c0_req_valid", imem_req_valid, 1);
      check("t5_first_addr", w_req_addr, 16'hFFFE);
      tick();
      check("t1_c1_dec_valid", dec_valid, 0);
      check("t5_second_addr", w_req_addr, 16'h0000);
      tick();
      check("t1_c2_dec_valid", dec_valid, 1);
      check("t1_c2_pc", dec_pc, 16'h0000);
      check("t1_c2_instr", dec_instr, 16'h1123);
      check("t1_c2_pc2", dec_pc_plus2, 16'h0002);
      check("t5_dec_pc", w_dec_pc, 16'hFFFE);
      check("t5_dec_pc2", w_dec_pc_plus2, 16'h0000);
      next_pop("t1_sub", 16'h0002, 16'h2456);
      next_pop("t1_lw", 16'h0004, 16'h8789);
      // decode stalled for 10 cycles
      do_reset(1'b0, 1);
      repeat (10) tick();
      check("t2_req_count", req_n, 2);
      check("t2_max_outstanding", max_out, 2);
      check("t2_head_valid", dec_valid, 1);
      check("t2_head_pc", dec_pc, 16'h0000);
      check("t2_head_instr", dec_instr, 16'h1123);
      dec_ready = 1'b1;
      next_pop("t2_second", 16'h0002, 16'h2456);
      next_pop("t2_third", 16'h0004, 16'h8789);
      // redirect (odd target) with two fetches in flight at latency 3
      do_reset(1'b1, 3);
      tick();
      tick();
      tick();
      check("t3_outstanding", due_q.size(), 2);
      check("t3_pre_dec_valid", dec_valid, 0);
      redirect_valid = 1'b1;
      redirect_pc = 16'h0041;
      tick();
      redirect_valid = 1'b0;
      check("t3_post_dec_valid", dec_valid, 0);
      check("t3_req_addr", imem_req_addr, 16'h0040);
      next_pop("t3_first", 16'h0040, 16'h3040);
      next_pop("t3_second", 16'h0042, 16'h3042);
`ifdef FETCH_PERF_CNT_EN
      tick();
      check("t6_fetch_count", fetch_count, 2);
      check("t6_drop_count", drop_count, 2);
`endif
      #3 rst = 1'b1;
      #1;
      check("t3_async_rst_dec_valid", dec_valid, 0);
      check("t3_async_rst_req_valid", imem_req_valid, 0);
`ifdef FETCH_PERF_CNT_EN
      check("t6_rst_fetch_count", fetch_count, 0);
      check("t6_rst_drop_count", drop_count, 0);
`endif
      // HLT at 0x0006
      hlt_on = 1'b1;
      do_reset(1'b1, 1);
      next_pop("t4_add", 16'h0000, 16'h1123);
      next_pop("t4_sub", 16'h0002, 16'h2456);
      next_pop("t4_lw", 16'h0004, 16'h8789);
      next_pop("t4_hlt", 16'h0006, 16'hF000);
      check("t4_not_yet_halted", halted, 0);
      tick();
      check("t4_halted", halted, 1);
      check("t4_halt_dec_valid", dec_valid, 0);
      redirect_valid = 1'b1;
      redirect_pc = 16'h0100;
      repeat (4) tick();
      redirect_valid = 1'b0;
      tick();
      check("t4_still_halted", halted, 1);
      check("t4_redir_ignored_addr", imem_req_addr, 16'h0008);
      check("t4_req_valid", imem_req_valid, 0);
      check("t4_dec_valid", dec_valid, 0);
      check("t4_late_requests", late_req, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
